// File: rtl/rv_dm_arbiter.sv
// rv_dm_arbiter: shares the data-memory port between the core load/store path and an aux master
module rv_dm_arbiter #(
  parameter int g_aux_starve_limit = 4,
  parameter bit g_core_priority = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] c_addr_i,
  input  logic [31:0] c_data_s_i,
  input  logic [3:0]  c_select_i,
  input  logic        c_load_i,
  input  logic        c_store_i,
  output logic        c_ready_o,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_data_s_i,
  input  logic [3:0]  a_select_i,
  input  logic        a_load_i,
  input  logic        a_store_i,
  output logic        a_ready_o,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_ready_i,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_data_s_o,
  output logic [3:0]  dm_data_select_o,
  output logic        dm_load_o,
  output logic        dm_store_o,
  output logic [31:0] c_data_l_o,
  output logic [31:0] a_data_l_o
);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_AUX  = 2'd2;
  logic [1:0] owner, win;
  logic [3:0] starve_cnt;
  logic c_req, a_req, starved, sel_c, sel_a, win_valid;
  assign c_req = c_load_i | c_store_i;
  assign a_req = a_load_i | a_store_i;
  assign starved = starve_cnt == 4'(g_aux_starve_limit);
  // A locked owner keeps the port; otherwise arbitrate fresh requests with the starvation override
  always_comb
    win = owner != OWN_NONE ? owner :
          c_req & a_req ? (starved | !g_core_priority ? OWN_AUX : OWN_CORE) :
          c_req ? OWN_CORE : a_req ? OWN_AUX : OWN_NONE;
  assign sel_c = win == OWN_CORE;
  assign sel_a = win == OWN_AUX;
  assign win_valid = (sel_c & c_req) | (sel_a & a_req);
  assign dm_addr_o = sel_c ? c_addr_i : sel_a ? a_addr_i : '0;
  assign dm_data_s_o = sel_c ? c_data_s_i : sel_a ? a_data_s_i : '0;
  assign dm_data_select_o = sel_c ? c_select_i : sel_a ? a_select_i : '0;
  assign dm_load_o = sel_c ? c_load_i : sel_a & a_load_i;
  assign dm_store_o = sel_c ? c_store_i : sel_a & a_store_i;
  assign c_ready_o = dm_ready_i & sel_c & c_req;
  assign a_ready_o = dm_ready_i & sel_a & a_req;
  assign c_data_l_o = dm_data_l_i;
  assign a_data_l_o = dm_data_l_i;
  // Lock on a stalled transaction; completion or an aborted request releases the port
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) owner <= OWN_NONE;
    else owner <= win_valid & !dm_ready_i ? win : OWN_NONE;
  // Count core completions while aux waits; aux completion or no aux request clears it
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) starve_cnt <= '0;
    else if (!a_req | a_ready_o) starve_cnt <= '0;
    else if (c_ready_o & !starved) starve_cnt <= starve_cnt + 4'd1;
endmodule

// File: doc/rv_dm_arbiter.md
Name: rv_dm_arbiter

Overview:
- Shares the single data-memory port between the execute stage load/store path and an auxiliary master (debug/DMA).
- Zero-latency pass-through when the port is idle.
- Locks ownership while a transaction is stalled on memory ready.
- Bounds auxiliary-master starvation with a fairness counter.
- Sits between the execute stage dm_* outputs and the external data bus.

Parameters:
g_aux_starve_limit, 4, max consecutive core transactions completed while aux is pending before aux is forced to win (1..15)
g_core_priority, 1, 1: core wins simultaneous fresh requests; 0: aux wins

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
c_addr_i  in  32  core address
c_data_s_i  in  32  core store data
c_select_i  in  4  core byte select
c_load_i  in  1  core load request
c_store_i  in  1  core store request
c_ready_o  out  1  core transaction complete
a_addr_i  in  32  aux address
a_data_s_i  in  32  aux store data
a_select_i  in  4  aux byte select
a_load_i  in  1  aux load request
a_store_i  in  1  aux store request
a_ready_o  out  1  aux transaction complete
dm_data_l_i  in  32  memory load data
dm_ready_i  in  1  memory ready
dm_addr_o  out  32  muxed address
dm_data_s_o  out  32  muxed store data
dm_data_select_o  out  4  muxed byte select
dm_load_o  out  1  muxed load
dm_store_o  out  1  muxed store
c_data_l_o  out  32  load data to core (= dm_data_l_i)
a_data_l_o  out  32  load data to aux (= dm_data_l_i)

Behaviour:
- Requests: c_req = c_load_i|c_store_i; a_req = a_load_i|a_store_i. Requesters hold all request fields stable until their ready is seen.
- Owner state: OWN_NONE, OWN_CORE, OWN_AUX. Reset: OWN_NONE, starve_cnt=0.
- Winner (combinational):
  - owner != NONE: winner = owner.
  - owner == NONE, single request: that requester.
  - owner == NONE, both request: aux if starve_cnt == g_aux_starve_limit; otherwise core if g_core_priority else aux.
  - No request: none.
- Muxing:
  - dm_* outputs carry the winner's fields.
  - No winner: dm_load_o=dm_store_o=0, dm_addr_o/dm_data_s_o/dm_data_select_o = 0.
  - Load and store both asserted by the winner are forwarded as-is (illegal; no correction).
- Ready: c_ready_o = dm_ready_i & winner==core & c_req; a_ready_o likewise for aux. The loser's ready is always 0, same cycle.
- Owner transitions at the clock edge:
  - winner valid & !dm_ready_i: owner <= winner (lock).
  - winner valid & dm_ready_i: owner <= NONE (back-to-back arbitration next cycle).
  - Locked owner's request deasserts without ready (abort): owner <= NONE. dm_* signals drop in that same cycle because they follow the request.
- Latency: 0 cycles request-to-bus. Completion occurs in the first cycle the winner sees dm_ready_i.
- Starvation counter (4 bits, saturating at g_aux_starve_limit):
  - +1 on each core completion while a_req=1.
  - Cleared on any aux completion, or in any cycle with a_req=0.
  - Holds otherwise.
- Reset mid-transaction: owner cleared immediately (async) and starve_cnt=0. Outputs follow the combinational winner from OWN_NONE. No replay of the in-flight transaction.
- Load data is unregistered broadcast; only the ready qualifies the consumer.

Test Plan:
- Core load only, dm_ready_i=1 -> dm_load_o=1 and dm_addr_o=c_addr_i same cycle; c_ready_o=1, a_ready_o=0; owner stays NONE.
- Core store, dm_ready_i low 3 cycles; aux request raised in cycle 1 -> dm_* held on core fields for 4 cycles; c_ready_o pulses in cycle 4; aux granted in cycle 5.
- Continuous core and aux requests, memory always ready, limit=4, g_core_priority=1 -> grant pattern C,C,C,C,A repeating; starve_cnt reads 0..4 then 0.
- g_core_priority=0, simultaneous fresh requests -> aux wins first; core wins the following cycle.
- Aux locked (dm_ready_i=0), then a_load_i drops -> dm_load_o=0 that cycle; owner NONE next cycle; pending core request granted.
- rst_i asserted asynchronously mid-lock -> owner NONE and starve_cnt=0 before the next edge; with no requests, dm_load_o=dm_store_o=0.
